fp_op_sequencer: RTL and testbench

//  Multicycle sequencer for the floating-point ALU ops (ALUControl 3'b100 FADD, 3'b101 FMUL).

---
 rtl/fp_seq_pkg.sv | 21 ++
 rtl/fp_lat_counter.sv | 36 +++
 rtl/fp_op_sequencer.sv | 131 +++++++++++++
 tb/tb_fp_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_seq_pkg.sv
// Shared definitions for the floating-point op sequencer and the decoder.
//   fp_state_e : sequencer state encoding
//   ALU_FADD / ALU_FMUL : ALUControl codes for the multicycle FP ops
//   max_int    : elaboration-time helper used to size the latency counter
package fp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fp_state_e;

  localparam logic [2:0] ALU_FADD = 3'b100;
  localparam logic [2:0] ALU_FMUL = 3'b101;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_lat_counter.sv
// Down-counter that times the FPU latency.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count clears to 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one; ignored when already zero
//   load_val   : value to load
//   zero       : count == 0
module fp_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fp_op_sequencer.sv
// Multicycle sequencer for FADD/FMUL. Stalls the single-cycle core while a
// pipelined FPU runs, then presents a registered result and {N,Z} flags
// with a one-cycle write-back strobe. Integer ALU codes pass straight through.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   Req, ALUControl       : valid DP op and its decoded ALU code
//   SrcA, SrcB            : operands from the datapath
//   fpu_result, fpu_flags : FPU result bus and its {N,Z} flags
//   fpu_start, fpu_op     : FPU launch pulse and op select (0=FADD, 1=FMUL)
//   FpA, FpB              : latched operands to the FPU
//   Stall                 : freeze PC and register-file write enable
//   ResultValid           : write-back strobe
//   FpResult, FpFlags     : captured result and flags
//
// state | meaning
// IDLE  | no op in flight; an FP request stalls at once and is latched
// ISSUE | fpu_start pulse, latency counter loaded with LAT-1
// WAIT  | counting down; result captured when the counter reaches zero
// DONE  | ResultValid, stall released, core retires the instruction
module fp_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic [1:0]       fpu_flags,
  output logic             fpu_start,
  output logic             fpu_op,
  output logic [WIDTH-1:0] FpA,
  output logic [WIDTH-1:0] FpB,
  output logic             Stall,
  output logic             ResultValid,
  output logic [WIDTH-1:0] FpResult,
  output logic [1:0]       FpFlags
);
  import fp_seq_pkg::*;

  localparam int CNT_W = $clog2(max_int(ADD_LAT, MUL_LAT)) + 1;
  localparam logic [CNT_W-1:0] ADD_LD = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);

  fp_state_e        state_d, state_q;
  logic             fpu_op_d, fpu_op_q;
  logic [WIDTH-1:0] fpa_d, fpa_q;
  logic [WIDTH-1:0] fpb_d, fpb_q;
  logic [WIDTH-1:0] res_d, res_q;
  logic [1:0]       flags_d, flags_q;

  logic fp_req;
  logic cnt_load, cnt_dec, cnt_zero;

  assign fp_req = Req & ((ALUControl == ALU_FADD) | (ALUControl == ALU_FMUL));

  assign cnt_load = (state_q == ISSUE);
  assign cnt_dec  = (state_q == WAIT) & ~cnt_zero;

  fp_lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (fpu_op_q ? MUL_LD : ADD_LD),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    fpu_op_d = fpu_op_q;
    fpa_d    = fpa_q;
    fpb_d    = fpb_q;
    res_d    = res_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (fp_req) begin
          fpa_d    = SrcA;
          fpb_d    = SrcB;
          fpu_op_d = ALUControl[0];
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_zero) begin
          res_d   = fpu_result;
          flags_d = fpu_flags;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      fpu_op_q <= 1'b0;
      fpa_q    <= '0;
      fpb_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpu_op_q <= fpu_op_d;
      fpa_q    <= fpa_d;
      fpb_q    <= fpb_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end

  // Stall in IDLE follows the request combinationally so the core freezes in
  // the same cycle; it is masked by reset so an aborted op releases the core.
  assign Stall       = ~reset & (((state_q == IDLE) & fp_req) |
                                 (state_q == ISSUE) | (state_q == WAIT));
  assign fpu_start   = (state_q == ISSUE);
  assign ResultValid = (state_q == DONE);
  assign fpu_op      = fpu_op_q;
  assign FpA         = fpa_q;
  assign FpB         = fpb_q;
  assign FpResult    = res_q;
  assign FpFlags     = flags_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
module tb_fp_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB, fpu_result;
  logic [1:0]  fpu_flags;
  logic        fpu_start, fpu_op, Stall, ResultValid;
  logic [31:0] FpA, FpB, FpResult;
  logic [1:0]  FpFlags;

  int tests = 0;
  int fails = 0;

  fp_op_sequencer #(.WIDTH(32), .ADD_LAT(3), .MUL_LAT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .Req         (Req),
    .ALUControl  (ALUControl),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .fpu_result  (fpu_result),
    .fpu_flags   (fpu_flags),
    .fpu_start   (fpu_start),
    .fpu_op      (fpu_op),
    .FpA         (FpA),
    .FpB         (FpB),
    .Stall       (Stall),
    .ResultValid (ResultValid),
    .FpResult    (FpResult),
    .FpFlags     (FpFlags)
  );

  always #5 clk = ~clk;

  // Issues one request at cycle 0 (inputs set at a negedge, sampled #1 later)
  // and measures the response over a bounded 20-cycle window.
  task automatic run_fp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [1:0] fl,
                        output int n_stall, output int n_start, output int n_rv, output int rv_at);
    n_stall = 0; n_start = 0; n_rv = 0; rv_at = -1;
    fpu_result = res; fpu_flags = fl;
    @(negedge clk);
    Req = 1'b1; ALUControl = code; SrcA = a; SrcB = b;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(negedge clk);
        Req = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
        #1;
      end
      if (Stall) n_stall++;
      if (fpu_start) n_start++;
      if (ResultValid) begin
        n_rv++;
        if (rv_at < 0) rv_at = c;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Req = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
    fpu_result = '0; fpu_flags = '0;
    @(negedge clk); #1;
    tests++;
    if ({Stall, fpu_start, ResultValid, fpu_op, FpFlags} !== 6'b0 ||
        FpA !== 32'h0 || FpB !== 32'h0 || FpResult !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got Stall=%b start=%b rv=%b op=%b A=%h B=%h R=%h F=%b, want all 0",
               Stall, fpu_start, ResultValid, fpu_op, FpA, FpB, FpResult, FpFlags);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (Stall !== 1'b0 || fpu_start !== 1'b0 || ResultValid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got Stall=%b start=%b rv=%b, want 0 0 0", Stall, fpu_start, ResultValid);
    end
  endtask

  task automatic test_fadd();
    int ns, nst, nrv, at;
    run_fp(3'b100, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, ns, nst, nrv, at);
    tests++;
    if (ns !== 5) begin fails++; $display("FAIL fadd_stall_cycles: got %0d want 5", ns); end
    tests++;
    if (nst !== 1 || nrv !== 1 || at !== 5) begin
      fails++;
      $display("FAIL fadd_pulses: got start=%0d rv=%0d rv_at=%0d want 1 1 5", nst, nrv, at);
    end
    tests++;
    if (FpResult !== 32'h40400000 || FpFlags !== 2'b00) begin
      fails++;
      $display("FAIL fadd_result: got %h/%b want 40400000/00", FpResult, FpFlags);
    end
    tests++;
    if (FpA !== 32'h3F800000 || FpB !== 32'h40000000 || fpu_op !== 1'b0) begin
      fails++;
      $display("FAIL fadd_operands: got A=%h B=%h op=%b want 3f800000 40000000 0", FpA, FpB, fpu_op);
    end
  endtask

  task automatic test_fmul();
    int ns, nst, nrv, at;
    run_fp(3'b101, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, ns, nst, nrv, at);
    tests++;
    if (ns !== 6) begin fails++; $display("FAIL fmul_stall_cycles: got %0d want 6", ns); end
    tests++;
    if (nst !== 1 || nrv !== 1 || at !== 6) begin
      fails++;
      $display("FAIL fmul_pulses: got start=%0d rv=%0d rv_at=%0d want 1 1 6", nst, nrv, at);
    end
    tests++;
    if (FpResult !== 32'h40C00000 || fpu_op !== 1'b1 || FpB !== 32'h40400000) begin
      fails++;
      $display("FAIL fmul_result: got R=%h op=%b B=%h want 40c00000 1 40400000", FpResult, fpu_op, FpB);
    end
  endtask

  task automatic test_int_passthrough();
    logic [2:0] codes [2];
    codes[0] = 3'b000; codes[1] = 3'b010;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        Req = 1'b1; ALUControl = codes[k]; SrcA = 32'hDEADBEEF; SrcB = 32'h12345678;
        #1;
        tests++;
        if (Stall !== 1'b0 || fpu_start !== 1'b0 || ResultValid !== 1'b0) begin
          fails++;
          $display("FAIL int_passthru code=%b cyc=%0d: got Stall=%b start=%b rv=%b want 0 0 0",
                   codes[k], c, Stall, fpu_start, ResultValid);
        end
      end
    end
    @(negedge clk); Req = 1'b0; ALUControl = 3'b000; #1;
    tests++;
    if (FpA !== 32'h40000000 || fpu_start !== 1'b0) begin
      fails++;
      $display("FAIL int_no_latch: got FpA=%h start=%b want 40000000 0", FpA, fpu_start);
    end
  endtask

  task automatic test_back_to_back();
    int rv1 = -1, rv2 = -1, nrv = 0;
    fpu_flags = 2'b00;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c == 0) begin
        Req = 1'b1; ALUControl = 3'b100; SrcA = 32'h11111111; SrcB = 32'h22222222;
      end else if (c <= 6) begin
        Req = 1'b1; ALUControl = 3'b101; SrcA = 32'h33333333; SrcB = 32'h44444444;
      end else begin
        Req = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
      end
      fpu_result = (c <= 5) ? 32'hAAAA0001 : 32'hBBBB0002;
      #1;
      if (ResultValid) begin
        nrv++;
        if (rv1 < 0) rv1 = c; else rv2 = c;
      end
      if (c == 3) begin
        tests++;
        if (fpu_op !== 1'b0 || FpA !== 32'h11111111) begin
          fails++;
          $display("FAIL b2b_first_held: got op=%b A=%h want 0 11111111", fpu_op, FpA);
        end
      end
      if (c == 5) begin
        tests++;
        if (FpResult !== 32'hAAAA0001 || Stall !== 1'b0) begin
          fails++;
          $display("FAIL b2b_first_result: got R=%h Stall=%b want aaaa0001 0", FpResult, Stall);
        end
      end
      if (c == 6) begin
        tests++;
        if (Stall !== 1'b1) begin fails++; $display("FAIL b2b_second_stall: got %b want 1", Stall); end
      end
      if (c == 7) begin
        tests++;
        if (FpA !== 32'h33333333 || FpB !== 32'h44444444 || fpu_op !== 1'b1 || fpu_start !== 1'b1) begin
          fails++;
          $display("FAIL b2b_second_issue: got A=%h B=%h op=%b start=%b want 33333333 44444444 1 1",
                   FpA, FpB, fpu_op, fpu_start);
        end
      end
    end
    tests++;
    if (nrv !== 2 || rv1 !== 5 || rv2 !== 12) begin
      fails++;
      $display("FAIL b2b_pulses: got n=%0d at %0d,%0d want 2 at 5,12", nrv, rv1, rv2);
    end
    tests++;
    if (FpResult !== 32'hBBBB0002) begin
      fails++;
      $display("FAIL b2b_second_result: got %h want bbbb0002", FpResult);
    end
  endtask

  task automatic test_reset_midop();
    int nrv = 0;
    int ns, nst, nr, at;
    fpu_result = 32'hCAFEF00D; fpu_flags = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      Req = (c == 0); ALUControl = (c == 0) ? 3'b101 : 3'b000;
      SrcA = 32'h55555555; SrcB = 32'h66666666;
      #1;
      if (ResultValid) nrv++;
    end
    // now in the second WAIT cycle of the FMUL
    reset = 1'b1;
    #1;
    tests++;
    if ({Stall, fpu_start, ResultValid, fpu_op, FpFlags} !== 6'b0 ||
        FpA !== 32'h0 || FpB !== 32'h0 || FpResult !== 32'h0) begin
      fails++;
      $display("FAIL midop_reset_outputs: got Stall=%b start=%b rv=%b op=%b A=%h B=%h R=%h F=%b want all 0",
               Stall, fpu_start, ResultValid, fpu_op, FpA, FpB, FpResult, FpFlags);
    end
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (ResultValid || Stall) nrv++;
    end
    tests++;
    if (nrv !== 0) begin fails++; $display("FAIL midop_no_valid: got %0d active cycles want 0", nrv); end
    run_fp(3'b100, 32'h3F800000, 32'h3F800000, 32'h40000000, 2'b00, ns, nst, nr, at);
    tests++;
    if (ns !== 5 || nr !== 1 || at !== 5 || FpResult !== 32'h40000000) begin
      fails++;
      $display("FAIL midop_recover: got stall=%0d rv=%0d at=%0d R=%h want 5 1 5 40000000", ns, nr, at, FpResult);
    end
  endtask

  task automatic test_flags();
    int ns, nst, nrv, at;
    run_fp(3'b100, 32'hBF800000, 32'hBF800000, 32'hC0000000, 2'b10, ns, nst, nrv, at);
    tests++;
    if (FpResult !== 32'hC0000000 || FpFlags !== 2'b10) begin
      fails++;
      $display("FAIL flags_neg: got %h/%b want c0000000/10", FpResult, FpFlags);
    end
    // FADD: WAIT in cycles 2..4, capture on the edge ending cycle 4
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      Req = (c == 0); ALUControl = (c == 0) ? 3'b100 : 3'b000;
      SrcA = 32'h1; SrcB = 32'h2;
      fpu_flags  = (c < 4) ? 2'b01 : (c == 4) ? 2'b10 : 2'b11;
      fpu_result = (c < 4) ? 32'h0000AAAA : (c == 4) ? 32'h0000BBBB : 32'h0000CCCC;
      #1;
      if (c == 3) begin
        tests++;
        if (FpFlags !== 2'b10) begin fails++; $display("FAIL flags_hold_prev: got %b want 10", FpFlags); end
      end
    end
    tests++;
    if (FpFlags !== 2'b10 || FpResult !== 32'h0000BBBB) begin
      fails++;
      $display("FAIL flags_capture_time: got %b/%h want 10/0000bbbb", FpFlags, FpResult);
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fmul();
    test_int_passthrough();
    test_back_to_back();
    test_reset_midop();
    test_flags();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
